// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-to-memory line interface: line geometry,
// responder FSM states and the address-to-line-index mapping used on both sides.
package mem_if_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } mem_state_e;

  // Drops the byte offset and wraps the result modulo the number of lines.
  function automatic logic [31:0] line_index(input logic [31:0] addr,
                                             input int unsigned lines);
    return (addr >> OFFSET_BITS) & (lines - 1);
  endfunction

endpackage

// File: rtl/line_memory_if.sv
// 256-bit line request/acknowledge bundle between the data cache (master) and main memory (slave).
// The initiator holds mem_enable_i until it sees the one-cycle mem_ack_o pulse.
interface line_memory_if;

  logic                               mem_enable_i;
  logic                               mem_write_i;
  logic [31:0]                        mem_addr_i;
  logic [mem_if_pkg::LINE_WIDTH-1:0]  mem_data_i;
  logic                               mem_ack_o;
  logic [mem_if_pkg::LINE_WIDTH-1:0]  mem_data_o;

  modport master (
    output mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    input  mem_ack_o, mem_data_o
  );

  modport slave (
    input  mem_enable_i, mem_write_i, mem_addr_i, mem_data_i,
    output mem_ack_o, mem_data_o
  );

endinterface

// File: rtl/line_memory_ram.sv
// Line storage: synchronous write, registered read whose output register is the memory's read-data output.
// Storage is never reset so contents survive rst_i; only the read register clears.
module line_ram
  import mem_if_pkg::*;
#(
  parameter  int LINES = 512,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic                  re_i,
  input  logic [IDX_W-1:0]      addr_i,
  input  logic [LINE_WIDTH-1:0] wdata_i,
  output logic [LINE_WIDTH-1:0] rdata_o
);

  logic [LINE_WIDTH-1:0] mem_q [LINES];
  logic [LINE_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/line_memory.sv
// Main-memory model answering line fills/write-backs: one request at a time, ack LATENCY edges after capture.
// Inputs are captured once in IDLE; everything after that runs from the captured copy.
module line_memory
  import mem_if_pkg::*;
#(
  parameter int MEM_LINES = 512,
  parameter int LATENCY   = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  line_memory_if.slave  mem
);

  localparam int         IDX_W    = $clog2(MEM_LINES);
  // Counter holds the number of BUSY cycles still to go, so ACK lands exactly LATENCY edges after capture.
  localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

  mem_state_e            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  wr_q, wr_d;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
  logic                  ack_q, ack_d;
  logic                  commit;
  logic                  ram_we, ram_re;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem.mem_enable_i) begin
          idx_d   = IDX_W'(line_index(mem.mem_addr_i, MEM_LINES));
          wr_d    = mem.mem_write_i;
          wdata_d = mem.mem_data_i;
          cnt_d   = CNT_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q == 8'd0) begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          state_d = ACK;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  // Reset on the commit edge drops the access, so an uncommitted write never reaches the array.
  assign ram_we = commit &  wr_q & ~rst_i;
  assign ram_re = commit & ~wr_q & ~rst_i;

  line_ram #(
    .LINES (MEM_LINES)
  ) u_ram (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem.mem_data_o)
  );

  assign mem.mem_ack_o = ack_q;

endmodule

// File: tb/tb_line_memory.sv
// Directed bench for line_memory: stimulus pushes expected ack cycle and read data, a negedge monitor pops and compares.
module tb_line_memory;
  import mem_if_pkg::*;

  localparam int L = 10;

  typedef struct {
    int                    cyc;
    logic [LINE_WIDTH-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_memory_if bus ();

  line_memory #(
    .MEM_LINES (512),
    .LATENCY   (L)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .mem   (bus)
  );

  exp_t                  sb[$];
  exp_t                  mon_e;
  int                    cyc    = 0;
  int                    n_cmp  = 0;
  int                    n_bad  = 0;
  logic [LINE_WIDTH-1:0] last_rd = '0;

  // Edge counter: after edge k the value seen at the following negedge is k.
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.mem_ack_o) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_ack: ack seen at edge %0d, none expected", cyc);
      end else begin
        mon_e = sb.pop_front();
        n_cmp++;
        if (cyc != mon_e.cyc) begin
          n_bad++;
          $display("FAIL ack_edge: got %0d want %0d", cyc, mon_e.cyc);
        end
        n_cmp++;
        if (bus.mem_data_o !== mon_e.data) begin
          n_bad++;
          $display("FAIL ack_data: got %h want %h", bus.mem_data_o, mon_e.data);
        end
      end
    end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL missing_ack: no ack by edge %0d (expected at %0d)", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
  end

  task automatic chk(input string name, input logic [LINE_WIDTH-1:0] act, input logic [LINE_WIDTH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic expect_ack(input int edge_no, input logic [LINE_WIDTH-1:0] d);
    exp_t e;
    e.cyc  = edge_no;
    e.data = d;
    sb.push_back(e);
  endtask

  // One request: ack expected L edges after the capture edge; a write must leave mem_data_o alone.
  task automatic do_req(input bit wr, input logic [31:0] addr,
                        input logic [LINE_WIDTH-1:0] data, input logic [LINE_WIDTH-1:0] exp_rd);
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = wr;
    bus.mem_addr_i   = addr;
    bus.mem_data_i   = data;
    expect_ack(cyc + 1 + L, wr ? last_rd : exp_rd);
    if (!wr) last_rd = exp_rd;
    @(negedge clk);
    bus.mem_enable_i = 1'b0;
    bus.mem_addr_i   = 32'hFFFF_FFE0;
    bus.mem_data_i   = ~data;
    repeat (L + 1) @(negedge clk);
  endtask

  task automatic do_rst(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst     = 1'b0;
    last_rd = '0;
  endtask

  initial begin
    logic [LINE_WIDTH-1:0] pa5, p11, pdb, pl0, p77, p55, p99;
    int e;
    pa5 = {32{8'hA5}};
    p11 = {64{4'h1}};
    pdb = {8{32'hDEAD_BEEF}};
    pl0 = {8{32'h0123_4567}};
    p77 = {32{8'h77}};
    p55 = {32{8'h55}};
    p99 = {32{8'h99}};

    bus.mem_enable_i = 1'b0;
    bus.mem_write_i  = 1'b0;
    bus.mem_addr_i   = '0;
    bus.mem_data_i   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ack", {255'd0, bus.mem_ack_o}, '0);
    chk("reset_data", bus.mem_data_o, '0);

    // Array contents survive reset.
    do_req(1'b1, 32'h60, pa5, '0);
    do_rst(2);
    chk("reset2_ack", {255'd0, bus.mem_ack_o}, '0);
    chk("reset2_data", bus.mem_data_o, '0);
    do_req(1'b0, 32'h60, '0, pa5);

    // Read latency and hold after ack.
    do_req(1'b1, 32'h60, p11, '0);
    do_req(1'b0, 32'h60, '0, p11);
    repeat (3) @(negedge clk);
    chk("read_hold", bus.mem_data_o, p11);

    // Write then read with a non-zero offset.
    do_req(1'b1, 32'h80, pdb, '0);
    chk("write_keeps_rdata", bus.mem_data_o, p11);
    do_req(1'b0, 32'h9F, '0, pdb);

    // Inputs perturbed mid-BUSY are ignored.
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = 1'b0;
    bus.mem_addr_i   = 32'h60;
    e = cyc + 1;
    expect_ack(e + L, p11);
    last_rd = p11;
    repeat (4) @(negedge clk);
    bus.mem_addr_i   = 32'h80;
    bus.mem_write_i  = 1'b1;
    bus.mem_data_i   = '0;
    bus.mem_enable_i = 1'b0;
    repeat (L) @(negedge clk);
    do_req(1'b0, 32'h80, '0, pdb);

    // Held enable: back-to-back service, address wraps to line 0.
    do_req(1'b1, 32'h0, pl0, '0);
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = 1'b0;
    bus.mem_addr_i   = 32'h4000;
    e = cyc + 1;
    expect_ack(e + L, pl0);
    expect_ack(e + L + 12, pl0);
    expect_ack(e + L + 24, pl0);
    last_rd = pl0;
    repeat (25) @(negedge clk);
    bus.mem_enable_i = 1'b0;
    repeat (L + 2) @(negedge clk);

    // Reset during BUSY drops the write.
    do_req(1'b1, 32'hE0, p77, '0);
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = 1'b1;
    bus.mem_addr_i   = 32'hE0;
    bus.mem_data_i   = p55;
    @(negedge clk);
    bus.mem_enable_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    last_rd = '0;
    chk("midop_reset_data", bus.mem_data_o, '0);
    chk("midop_reset_ack", {255'd0, bus.mem_ack_o}, '0);
    repeat (L + 2) @(negedge clk);
    do_req(1'b0, 32'hE0, '0, p77);

    // Reset during ACK keeps the already committed write.
    @(negedge clk);
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = 1'b1;
    bus.mem_addr_i   = 32'h120;
    bus.mem_data_i   = p99;
    e = cyc + 1;
    expect_ack(e + L, last_rd);
    @(negedge clk);
    bus.mem_enable_i = 1'b0;
    repeat (L) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst     = 1'b0;
    last_rd = '0;
    do_req(1'b0, 32'h120, '0, p99);

    // Enable coincident with reset: no capture.
    @(negedge clk);
    rst              = 1'b1;
    bus.mem_enable_i = 1'b1;
    bus.mem_write_i  = 1'b0;
    bus.mem_addr_i   = 32'h60;
    @(negedge clk);
    rst              = 1'b0;
    bus.mem_enable_i = 1'b0;
    last_rd          = '0;
    repeat (L + 3) @(negedge clk);
    chk("rst_en_ack", {255'd0, bus.mem_ack_o}, '0);
    chk("rst_en_data", bus.mem_data_o, '0);

    repeat (5) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL leftover_expect: %0d acks never seen, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
